// File: rtl/banco_registros_sb.sv
// ---------------------------------------------------------------------------
// banco_registros_sb
//
// Purpose:
//   Register bank for the MIPS32 datapath, placed between decode and
//   writeback. It has two combinational read ports, one synchronous write
//   port, optional write-to-read bypass and a pending (scoreboard) bit per
//   register. Decode uses the pending bits to detect load-use and
//   multi-cycle hazards. The register count is 2^ADDR_W.
//
// Parameters:
//   DATA_W   - register width
//   ADDR_W   - address width (depth = 2^ADDR_W)
//   ZERO_REG - 1: register 0 reads 0 and ignores writes and issue marks
//   BYPASS   - 1: a write in the current cycle is forwarded to matching reads
//
// Ports:
//   clk, rst_n                 - rising-edge clock, async active-low reset
//   R_register_1/2, R_data_1/2 - read addresses and combinational read data
//   W_register, W_data, RegEn  - write port; RegEn also retires pending bit
//   Issue_en, Issue_reg        - marks a destination as pending
//   Busy_1/2                   - pending status seen by each read port
//   Busy_count                 - number of registers currently pending
// ---------------------------------------------------------------------------
module banco_registros_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] R_register_1,
    input  logic [ADDR_W-1:0] R_register_2,
    output logic [DATA_W-1:0] R_data_1,
    output logic [DATA_W-1:0] R_data_2,
    input  logic [ADDR_W-1:0] W_register,
    input  logic [DATA_W-1:0] W_data,
    input  logic              RegEn,
    input  logic              Issue_en,
    input  logic [ADDR_W-1:0] Issue_reg,
    output logic              Busy_1,
    output logic              Busy_2,
    output logic [ADDR_W:0]   Busy_count
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam bit BYP_EN  = (BYPASS != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_next;

    logic write_ok;
    logic issue_ok;
    logic rise;
    logic fall;

    // A write or issue aimed at the hardwired zero register is discarded.
    assign write_ok = RegEn && !(ZERO_EN && (W_register == '0));
    assign issue_ok = Issue_en && !(ZERO_EN && (Issue_reg == '0));

    // Busy_count moves only on real bit transitions. A set on an idle
    // register adds one; a writeback to a pending register removes one,
    // unless the same register is re-issued this cycle (set wins, so the
    // bit never drops).
    assign rise = issue_ok && !pend[Issue_reg];
    assign fall = RegEn && pend[W_register] && !(issue_ok && (Issue_reg == W_register));

    // Next pending vector: clear first, then set, so set overrides clear.
    always_comb begin
        pend_next = pend;
        if (RegEn) begin
            pend_next[W_register] = 1'b0;
        end
        if (issue_ok) begin
            pend_next[Issue_reg] = 1'b1;
        end
    end

    // Register array with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_ok) begin
            mem[W_register] <= W_data;
        end
    end

    // Scoreboard bits and the running count of pending registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            Busy_count <= '0;
        end else begin
            pend       <= pend_next;
            Busy_count <= Busy_count + {{ADDR_W{1'b0}}, rise} - {{ADDR_W{1'b0}}, fall};
        end
    end

    // Read port 1: zero register, then bypass from the write port, then array.
    // Busy is hidden while the value is being written back this cycle.
    always_comb begin
        R_data_1 = mem[R_register_1];
        Busy_1   = pend[R_register_1];
        if (BYP_EN && write_ok && (W_register == R_register_1)) begin
            R_data_1 = W_data;
        end
        if (BYP_EN && RegEn && (W_register == R_register_1)) begin
            Busy_1 = 1'b0;
        end
        if (ZERO_EN && (R_register_1 == '0)) begin
            R_data_1 = '0;
            Busy_1   = 1'b0;
        end
    end

    // Read port 2: same structure as port 1, fully independent.
    always_comb begin
        R_data_2 = mem[R_register_2];
        Busy_2   = pend[R_register_2];
        if (BYP_EN && write_ok && (W_register == R_register_2)) begin
            R_data_2 = W_data;
        end
        if (BYP_EN && RegEn && (W_register == R_register_2)) begin
            Busy_2 = 1'b0;
        end
        if (ZERO_EN && (R_register_2 == '0)) begin
            R_data_2 = '0;
            Busy_2   = 1'b0;
        end
    end

endmodule

// File: tb/tb_banco_registros_sb.sv
// ---------------------------------------------------------------------------
// tb_banco_registros_sb
//
// Drives two copies of the register bank from the same stimulus: one with
// the default configuration (ZERO_REG=1, BYPASS=1) and one with ZERO_REG=0,
// BYPASS=0. Each directed vector pushes its hand-computed expectation into a
// queue; an independent monitor pops one entry per cycle on the falling edge
// and compares the selected fields.
// ---------------------------------------------------------------------------
module tb_banco_registros_sb;

    localparam int M_D1   = 1;
    localparam int M_D2   = 2;
    localparam int M_B1   = 4;
    localparam int M_B2   = 8;
    localparam int M_CNT  = 16;
    localparam int M_AD1  = 32;
    localparam int M_ACNT = 64;
    localparam int M_ALL  = 127;

    typedef struct {
        string       name;
        int          mask;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
        logic [5:0]  cnt;
        logic [31:0] ad1;
        logic [5:0]  acnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  R_register_1;
    logic [4:0]  R_register_2;
    logic [4:0]  W_register;
    logic [31:0] W_data;
    logic        RegEn;
    logic        Issue_en;
    logic [4:0]  Issue_reg;

    logic [31:0] R_data_1;
    logic [31:0] R_data_2;
    logic        Busy_1;
    logic        Busy_2;
    logic [5:0]  Busy_count;

    logic [31:0] alt_data_1;
    logic [31:0] alt_data_2;
    logic        alt_busy_1;
    logic        alt_busy_2;
    logic [5:0]  alt_count;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    banco_registros_sb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .R_register_1 (R_register_1),
        .R_register_2 (R_register_2),
        .R_data_1     (R_data_1),
        .R_data_2     (R_data_2),
        .W_register   (W_register),
        .W_data       (W_data),
        .RegEn        (RegEn),
        .Issue_en     (Issue_en),
        .Issue_reg    (Issue_reg),
        .Busy_1       (Busy_1),
        .Busy_2       (Busy_2),
        .Busy_count   (Busy_count)
    );

    banco_registros_sb #(
        .ZERO_REG (0),
        .BYPASS   (0)
    ) dut_alt (
        .clk          (clk),
        .rst_n        (rst_n),
        .R_register_1 (R_register_1),
        .R_register_2 (R_register_2),
        .R_data_1     (alt_data_1),
        .R_data_2     (alt_data_2),
        .W_register   (W_register),
        .W_data       (W_data),
        .RegEn        (RegEn),
        .Issue_en     (Issue_en),
        .Issue_reg    (Issue_reg),
        .Busy_1       (alt_busy_1),
        .Busy_2       (alt_busy_2),
        .Busy_count   (alt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input string name, input int mask,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic b1, input logic b2, input logic [5:0] cnt,
                                input logic [31:0] ad1, input logic [5:0] acnt);
        exp_t e;
        e.name = name;
        e.mask = mask;
        e.d1   = d1;
        e.d2   = d2;
        e.b1   = b1;
        e.b2   = b2;
        e.cnt  = cnt;
        e.ad1  = ad1;
        e.acnt = acnt;
        return e;
    endfunction

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string name, input string field,
                               input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, actual, expected);
        end
    endtask

    // Drives one cycle of inputs (just after a rising edge), queues the
    // expected outputs for that cycle, then advances to the next cycle.
    task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2,
                                 input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                 input logic ie, input logic [4:0] ir, input exp_t e);
        R_register_1 = r1;
        R_register_2 = r2;
        RegEn        = we;
        W_register   = wr;
        W_data       = wd;
        Issue_en     = ie;
        Issue_reg    = ir;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if ((e.mask & M_D1)   != 0) checkOutput(e.name, "R_data_1",   R_data_1,         e.d1);
            if ((e.mask & M_D2)   != 0) checkOutput(e.name, "R_data_2",   R_data_2,         e.d2);
            if ((e.mask & M_B1)   != 0) checkOutput(e.name, "Busy_1",     32'(Busy_1),      32'(e.b1));
            if ((e.mask & M_B2)   != 0) checkOutput(e.name, "Busy_2",     32'(Busy_2),      32'(e.b2));
            if ((e.mask & M_CNT)  != 0) checkOutput(e.name, "Busy_count", 32'(Busy_count),  32'(e.cnt));
            if ((e.mask & M_AD1)  != 0) checkOutput(e.name, "alt_data_1", alt_data_1,       e.ad1);
            if ((e.mask & M_ACNT) != 0) checkOutput(e.name, "alt_count",  32'(alt_count),   32'(e.acnt));
        end
    end

    initial begin
        rst_n        = 1'b0;
        R_register_1 = '0;
        R_register_2 = '0;
        W_register   = '0;
        W_data       = '0;
        RegEn        = 1'b0;
        Issue_en     = 1'b0;
        Issue_reg    = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset contents: every address reads zero and idle.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(5'(i), 5'(31 - i), 0, 0, 0, 0, 0,
                          mk("reset_read", M_ALL, 0, 0, 0, 0, 0, 0, 0));
        end

        // Write with same-cycle bypass; alt copy still shows the old value.
        applyStimulus(5, 6, 1, 5, 32'hDEADBEEF, 0, 0,
                      mk("wr5_cycle", M_ALL, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0));
        applyStimulus(5, 6, 0, 0, 0, 0, 0,
                      mk("wr5_after", M_ALL, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 0));

        // Zero register: writes and issue marks are dropped on the main copy.
        applyStimulus(0, 0, 1, 0, 32'h12345678, 0, 0,
                      mk("wr0_cycle", M_D1 | M_D2 | M_CNT | M_AD1, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, 0, 0, 0, 0, 1, 0,
                      mk("iss0_cycle", M_ALL, 0, 0, 0, 0, 0, 32'h12345678, 0));
        applyStimulus(0, 0, 0, 0, 0, 0, 0,
                      mk("iss0_after", M_ALL, 0, 0, 0, 0, 0, 32'h12345678, 1));

        // Scoreboard: issue 3 then 7.
        applyStimulus(3, 0, 0, 0, 0, 1, 3,
                      mk("iss3", M_B1 | M_CNT, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(3, 0, 0, 0, 0, 1, 7,
                      mk("iss7", M_B1 | M_CNT | M_ACNT, 0, 0, 1, 0, 1, 0, 2));
        applyStimulus(3, 7, 0, 0, 0, 0, 0,
                      mk("busy_3_7", M_B1 | M_B2 | M_CNT | M_ACNT, 0, 0, 1, 1, 2, 0, 3));

        // Writeback to 3: busy hidden during the write, count drops after.
        applyStimulus(3, 7, 1, 3, 32'hA5A5A5A5, 0, 0,
                      mk("wb3_cycle", M_ALL, 32'hA5A5A5A5, 0, 0, 1, 2, 0, 3));
        applyStimulus(3, 7, 0, 0, 0, 0, 0,
                      mk("wb3_after", M_ALL, 32'hA5A5A5A5, 0, 0, 1, 1, 32'hA5A5A5A5, 2));

        // Issue and writeback to 7 together: set wins, count unchanged.
        applyStimulus(7, 3, 1, 7, 32'h00000077, 1, 7,
                      mk("setclr7_cycle", M_D1 | M_B1 | M_CNT | M_ACNT, 32'h77, 0, 0, 0, 1, 0, 2));
        applyStimulus(7, 3, 0, 0, 0, 0, 0,
                      mk("setclr7_after", M_ALL, 32'h77, 32'hA5A5A5A5, 1, 0, 1, 32'h77, 2));

        // Issue 9 while 7 retires: count unchanged.
        applyStimulus(9, 7, 1, 7, 32'h00000700, 1, 9,
                      mk("iss9_wb7_cycle", M_ALL, 0, 32'h700, 0, 0, 1, 0, 2));
        applyStimulus(9, 7, 0, 0, 0, 0, 0,
                      mk("iss9_wb7_after", M_ALL, 0, 32'h700, 1, 0, 1, 0, 2));

        // Re-issue to a pending register: count unchanged.
        applyStimulus(9, 0, 0, 0, 0, 1, 9,
                      mk("reiss9_cycle", M_B1 | M_CNT, 0, 0, 1, 0, 1, 0, 0));
        applyStimulus(9, 0, 0, 0, 0, 0, 0,
                      mk("reiss9_after", M_B1 | M_CNT | M_ACNT, 0, 0, 1, 0, 1, 0, 2));

        // Build up four pending registers (9..12).
        applyStimulus(10, 0, 0, 0, 0, 1, 10, mk("iss10", M_CNT, 0, 0, 0, 0, 1, 0, 0));
        applyStimulus(11, 0, 0, 0, 0, 1, 11, mk("iss11", M_CNT, 0, 0, 0, 0, 2, 0, 0));
        applyStimulus(12, 0, 0, 0, 0, 1, 12, mk("iss12", M_CNT, 0, 0, 0, 0, 3, 0, 0));
        applyStimulus(5, 3, 0, 0, 0, 0, 0,
                      mk("four_pending", M_ALL, 32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 4, 32'hDEADBEEF, 5));

        // Asynchronous reset between clock edges.
        rst_n = 1'b0;
        applyStimulus(5, 3, 0, 0, 0, 0, 0,
                      mk("async_reset", M_ALL, 0, 0, 0, 0, 0, 0, 0));

        // First write after reset release, then both ports bypassing at once.
        rst_n = 1'b1;
        applyStimulus(5, 0, 1, 5, 32'h00000055, 0, 0,
                      mk("post_reset_wr", M_D1 | M_D2 | M_CNT | M_AD1, 32'h55, 0, 0, 0, 0, 0, 0));
        applyStimulus(20, 20, 1, 20, 32'hCAFEF00D, 0, 0,
                      mk("dual_bypass", M_D1 | M_D2 | M_AD1, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 0, 0, 0));
        applyStimulus(5, 31, 1, 31, 32'h31313131, 0, 0,
                      mk("wr31_cycle", M_D1 | M_D2 | M_AD1, 32'h55, 32'h31313131, 0, 0, 0, 32'h55, 0));
        applyStimulus(31, 20, 0, 0, 0, 0, 0,
                      mk("wr31_after", M_D1 | M_D2 | M_AD1 | M_CNT, 32'h31313131, 32'hCAFEF00D, 0, 0, 0,
                         32'h31313131, 0));

        // Every queued expectation must have been consumed by now.
        @(negedge clk);
        #1;
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
